// File: rtl/coin_change_dispenser_pkg.sv
// Shared constants and FSM state type for the coin change dispenser.
// Coin index order matches the hopper request bits: [0]=100, [1]=500, [2]=1000.
package coin_change_dispenser_pkg;

  localparam int unsigned NumCoins    = 3;
  localparam int unsigned CoinIdx100  = 0;
  localparam int unsigned CoinIdx500  = 1;
  localparam int unsigned CoinIdx1000 = 2;

  localparam int unsigned CoinVal100  = 100;
  localparam int unsigned CoinVal500  = 500;
  localparam int unsigned CoinVal1000 = 1000;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StDispense,
    StFinish
  } state_e;

  function automatic int unsigned coin_value(input int unsigned idx);
    case (idx)
      CoinIdx100:  return CoinVal100;
      CoinIdx500:  return CoinVal500;
      CoinIdx1000: return CoinVal1000;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_change_dispenser_inventory_counter.sv
// Saturating per-denomination coin counter: +REFILL_QTY on inc, -1 on dec, both may coincide.
// Never wraps above 2^INV_W-1 and never goes below zero.
module coin_inventory_counter #(
  parameter int unsigned INV_W      = 8,
  parameter int unsigned INV_INIT   = 20,
  parameter int unsigned REFILL_QTY = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [INV_W-1:0] count
);

  localparam logic [INV_W:0]   Refill  = REFILL_QTY[INV_W:0];
  localparam logic [INV_W:0]   One     = 1;
  localparam logic [INV_W:0]   Max     = {1'b0, {INV_W{1'b1}}};
  localparam logic [INV_W-1:0] InitVal = INV_INIT[INV_W-1:0];

  logic [INV_W:0] sum;
  logic [INV_W:0] count_d;

  // One spare bit of headroom lets refill overflow be detected before clamping.
  always_comb begin
    sum     = {1'b0, count} + (inc ? Refill : '0);
    count_d = sum;
    if (dec && (sum != '0)) begin
      count_d = sum - One;
    end
    if (count_d > Max) begin
      count_d = Max;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= InitVal;
    end else begin
      count <= count_d[INV_W-1:0];
    end
  end

endmodule

// File: rtl/coin_change_dispenser.sv
// Pays out a change amount as 1000/500/100 coins through a req/ack hopper, largest coin first,
// falling back to smaller coins when a tube is empty; aborts the request on hopper timeout.
module coin_change_dispenser
  import coin_change_dispenser_pkg::*;
#(
  parameter int unsigned AMOUNT_W    = 31,
  parameter int unsigned INV_W       = 8,
  parameter int unsigned INV_INIT    = 20,
  parameter int unsigned REFILL_QTY  = 10,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [AMOUNT_W-1:0] i_req_amount,
  input  logic [2:0]          i_refill,
  output logic [2:0]          o_hopper_req,
  input  logic                i_hopper_ack,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_short,
  output logic [AMOUNT_W-1:0] o_remaining,
  output logic [INV_W-1:0]    o_inv_100,
  output logic [INV_W-1:0]    o_inv_500,
  output logic [INV_W-1:0]    o_inv_1000
);

  localparam int unsigned TO_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] ToLast = TO_W'(ACK_TIMEOUT - 1);

  localparam logic [AMOUNT_W-1:0] Val100  = AMOUNT_W'(CoinVal100);
  localparam logic [AMOUNT_W-1:0] Val500  = AMOUNT_W'(CoinVal500);
  localparam logic [AMOUNT_W-1:0] Val1000 = AMOUNT_W'(CoinVal1000);

  state_e                state;
  logic [TO_W-1:0]       to_cnt;
  logic [2:0]            pick;
  logic [AMOUNT_W-1:0]   req_val;
  logic [NumCoins-1:0]   dec;

  // Greedy choice from the current balance and non-empty tubes.
  always_comb begin
    pick = 3'b000;
    if ((o_remaining >= Val1000) && (o_inv_1000 != '0)) begin
      pick = 3'b100;
    end else if ((o_remaining >= Val500) && (o_inv_500 != '0)) begin
      pick = 3'b010;
    end else if ((o_remaining >= Val100) && (o_inv_100 != '0)) begin
      pick = 3'b001;
    end
  end

  always_comb begin
    req_val = '0;
    unique case (o_hopper_req)
      3'b001:  req_val = Val100;
      3'b010:  req_val = Val500;
      3'b100:  req_val = Val1000;
      default: req_val = '0;
    endcase
  end

  // A coin is consumed only on an ack while actually dispensing.
  assign dec = ((state == StDispense) && i_hopper_ack) ? o_hopper_req : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= StIdle;
      to_cnt       <= '0;
      o_hopper_req <= 3'b000;
      o_req_ready  <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_short      <= 1'b0;
      o_remaining  <= '0;
    end else begin
      o_done  <= 1'b0;
      o_short <= 1'b0;
      case (state)
        StIdle: begin
          if (i_req_valid) begin
            o_remaining <= i_req_amount;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            state       <= StSelect;
          end
        end
        StSelect: begin
          if (pick != 3'b000) begin
            o_hopper_req <= pick;
            to_cnt       <= '0;
            state        <= StDispense;
          end else begin
            o_done  <= 1'b1;
            o_short <= (o_remaining != '0);
            state   <= StFinish;
          end
        end
        StDispense: begin
          if (i_hopper_ack) begin
            o_remaining  <= o_remaining - req_val;
            o_hopper_req <= 3'b000;
            state        <= StSelect;
          end else if (to_cnt == ToLast) begin
            o_hopper_req <= 3'b000;
            o_done       <= 1'b1;
            o_short      <= (o_remaining != '0);
            state        <= StFinish;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        StFinish: begin
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
          state       <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  coin_inventory_counter #(
    .INV_W      (INV_W),
    .INV_INIT   (INV_INIT),
    .REFILL_QTY (REFILL_QTY)
  ) u_inv_100 (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (i_refill[CoinIdx100]),
    .dec     (dec[CoinIdx100]),
    .count   (o_inv_100)
  );

  coin_inventory_counter #(
    .INV_W      (INV_W),
    .INV_INIT   (INV_INIT),
    .REFILL_QTY (REFILL_QTY)
  ) u_inv_500 (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (i_refill[CoinIdx500]),
    .dec     (dec[CoinIdx500]),
    .count   (o_inv_500)
  );

  coin_inventory_counter #(
    .INV_W      (INV_W),
    .INV_INIT   (INV_INIT),
    .REFILL_QTY (REFILL_QTY)
  ) u_inv_1000 (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (i_refill[CoinIdx1000]),
    .dec     (dec[CoinIdx1000]),
    .count   (o_inv_1000)
  );

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Bench for coin_change_dispenser: two instances (INV_INIT 20 and 1), a transaction-level
// payout model checked every cycle, and directed transactions with literal expectations.
module tb_coin_change_dispenser;

  localparam int AW = 31;
  localparam int IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          valid   [2];
  logic [AW-1:0] amount  [2];
  logic [2:0]    refill  [2];
  logic          ack     [2] = '{1'b0, 1'b0};
  logic          ready   [2];
  logic [2:0]    hreq    [2];
  logic          busy    [2];
  logic          done    [2];
  logic          short_o [2];
  logic [AW-1:0] rem     [2];
  logic [IW-1:0] inv100  [2];
  logic [IW-1:0] inv500  [2];
  logic [IW-1:0] inv1000 [2];
  bit            hop_en  [2];

  int n_vec = 0;
  int n_err = 0;

  coin_change_dispenser u_dut0 (
    .clk (clk), .reset_n (reset_n), .i_req_valid (valid[0]), .o_req_ready (ready[0]),
    .i_req_amount (amount[0]), .i_refill (refill[0]), .o_hopper_req (hreq[0]),
    .i_hopper_ack (ack[0]), .o_busy (busy[0]), .o_done (done[0]), .o_short (short_o[0]),
    .o_remaining (rem[0]), .o_inv_100 (inv100[0]), .o_inv_500 (inv500[0]),
    .o_inv_1000 (inv1000[0])
  );

  coin_change_dispenser #(.INV_INIT (1)) u_dut1 (
    .clk (clk), .reset_n (reset_n), .i_req_valid (valid[1]), .o_req_ready (ready[1]),
    .i_req_amount (amount[1]), .i_refill (refill[1]), .o_hopper_req (hreq[1]),
    .i_hopper_ack (ack[1]), .o_busy (busy[1]), .o_done (done[1]), .o_short (short_o[1]),
    .o_remaining (rem[1]), .o_inv_100 (inv100[1]), .o_inv_500 (inv500[1]),
    .o_inv_1000 (inv1000[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hopper stand-in: acks one cycle after a request appears when enabled.
  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 2; u++) ack[u] = hop_en[u] && (hreq[u] != 3'b000) && reset_n;
  end

  // ---------------- behavioural model ----------------
  int         coin_val [3] = '{100, 500, 1000};
  int         m_rem    [2];
  int         m_inv    [2][3];
  logic [2:0] p_req    [2];
  logic       p_ack    [2];
  logic       p_valid  [2];
  logic       p_ready  [2];
  logic [2:0] p_refill [2];
  int         p_amount [2];
  int         held     [2];
  bit         timed_out[2];
  logic [2:0] log0 [$];
  logic [2:0] log1 [$];

  function automatic int init_of(input int u);
    return (u == 0) ? 20 : 1;
  endfunction

  // Largest coin that fits the balance and is in stock, as a one-hot request pattern.
  function automatic int greedy(input int r, input int i100, input int i500, input int i1000);
    if (r >= 1000 && i1000 > 0) return 4;
    if (r >= 500 && i500 > 0) return 2;
    if (r >= 100 && i100 > 0) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int u = 0; u < 2; u++) begin
        m_rem[u] = 0;
        for (int d = 0; d < 3; d++) m_inv[u][d] = init_of(u);
        p_req[u] = 3'b000; p_ack[u] = 1'b0; p_valid[u] = 1'b0; p_ready[u] = 1'b1;
        p_refill[u] = 3'b000; p_amount[u] = 0; held[u] = 0; timed_out[u] = 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        int acc;
        int nxt;
        int oinv [3];
        acc = -1;
        for (int d = 0; d < 3; d++) oinv[d] = m_inv[u][d];
        if (p_valid[u] && p_ready[u]) begin
          m_rem[u] = p_amount[u];
          timed_out[u] = 0;
        end
        if (p_req[u] != 3'b000 && p_ack[u]) begin
          for (int d = 0; d < 3; d++) if (p_req[u][d]) acc = d;
          m_rem[u] = m_rem[u] - coin_val[acc];
        end
        for (int d = 0; d < 3; d++) begin
          nxt = m_inv[u][d] + (p_refill[u][d] ? 10 : 0) - ((acc == d) ? 1 : 0);
          if (nxt > 255) nxt = 255;
          if (nxt < 0) nxt = 0;
          m_inv[u][d] = nxt;
        end

        check($sformatf("inv_100[%0d]", u), 64'(inv100[u]), 64'(m_inv[u][0]));
        check($sformatf("inv_500[%0d]", u), 64'(inv500[u]), 64'(m_inv[u][1]));
        check($sformatf("inv_1000[%0d]", u), 64'(inv1000[u]), 64'(m_inv[u][2]));
        check($sformatf("req_onehot[%0d]", u), 64'($countones(hreq[u]) <= 1), 64'd1);
        check($sformatf("ready_vs_busy[%0d]", u), 64'(ready[u]), 64'(!busy[u]));

        if (p_req[u] == 3'b000 && hreq[u] != 3'b000) begin
          check($sformatf("req_pick[%0d]", u), 64'(hreq[u]),
                64'(greedy(m_rem[u], oinv[0], oinv[1], oinv[2])));
          held[u] = 1;
          if (u == 0) log0.push_back(hreq[u]); else log1.push_back(hreq[u]);
        end else if (p_req[u] != 3'b000 && hreq[u] != 3'b000) begin
          check($sformatf("req_stable[%0d]", u), 64'(hreq[u]), 64'(p_req[u]));
          held[u]++;
        end else if (p_req[u] != 3'b000 && !p_ack[u]) begin
          check($sformatf("timeout_len[%0d]", u), 64'(held[u]), 64'd16);
          timed_out[u] = 1;
        end

        if (done[u]) begin
          check($sformatf("done_short[%0d]", u), 64'(short_o[u]), 64'(m_rem[u] != 0));
          check($sformatf("done_remaining[%0d]", u), 64'(rem[u]), 64'(m_rem[u]));
          if (!timed_out[u])
            check($sformatf("done_no_coin_left[%0d]", u),
                  64'(greedy(m_rem[u], oinv[0], oinv[1], oinv[2])), 64'd0);
        end

        p_req[u] = hreq[u]; p_ack[u] = ack[u]; p_valid[u] = valid[u]; p_ready[u] = ready[u];
        p_refill[u] = refill[u]; p_amount[u] = int'(amount[u]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int u, input int amt);
    int k;
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (ready[u]) break;
    end
    if (k == 100) check("send_ready_timeout", 64'd0, 64'd1);
    valid[u] = 1'b1;
    amount[u] = AW'(amt);
    @(posedge clk); #1;
    valid[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, output logic s, output int r, output int req_cycles);
    int k;
    req_cycles = 0;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (hreq[u] != 3'b000) req_cycles++;
      if (done[u]) break;
    end
    if (k == 400) check("done_timeout", 64'd0, 64'd1);
    s = short_o[u];
    r = int'(rem[u]);
  endtask

  task automatic wait_req(input int u);
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (hreq[u] != 3'b000) break;
    end
    if (k == 50) check("req_wait_timeout", 64'd0, 64'd1);
  endtask

  logic s;
  int   r;
  int   rc;
  logic [2:0] exp2 [6] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001};
  logic [2:0] exp3 [3] = '{3'b100, 3'b010, 3'b001};

  initial begin
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      valid[u] = 1'b0; amount[u] = '0; refill[u] = 3'b000; hop_en[u] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready", 64'(ready[0]), 64'd1);
    check("rst_req", 64'(hreq[0]), 64'd0);
    check("rst_inv_100", 64'(inv100[0]), 64'd20);
    check("rst_inv_500", 64'(inv500[0]), 64'd20);
    check("rst_inv_1000", 64'(inv1000[0]), 64'd20);
    check("rst_remaining", 64'(rem[0]), 64'd0);
    check("rst_done", 64'(done[0]), 64'd0);
    check("rst_inv1_1000", 64'(inv1000[1]), 64'd1);

    // 2800 with a prompt hopper
    log0.delete();
    send(0, 2800);
    wait_done(0, s, r, rc);
    check("t2_short", 64'(s), 64'd0);
    check("t2_remaining", 64'(r), 64'd0);
    check("t2_coin_count", 64'(log0.size()), 64'd6);
    for (int i = 0; i < 6 && i < log0.size(); i++) check("t2_coin_seq", 64'(log0[i]), 64'(exp2[i]));
    check("t2_inv_1000", 64'(inv1000[0]), 64'd18);
    check("t2_inv_500", 64'(inv500[0]), 64'd19);
    check("t2_inv_100", 64'(inv100[0]), 64'd17);

    // Single coin per tube: 2000 pays 1000+500+100 and falls 400 short, then all tubes empty
    log1.delete();
    send(1, 2000);
    wait_done(1, s, r, rc);
    check("t3_short", 64'(s), 64'd1);
    check("t3_remaining", 64'(r), 64'd400);
    check("t3_coin_count", 64'(log1.size()), 64'd3);
    for (int i = 0; i < 3 && i < log1.size(); i++) check("t3_coin_seq", 64'(log1[i]), 64'(exp3[i]));
    log1.delete();
    send(1, 100);
    wait_done(1, s, r, rc);
    check("t3b_short", 64'(s), 64'd1);
    check("t3b_remaining", 64'(r), 64'd100);
    check("t3b_no_req", 64'(log1.size()), 64'd0);

    // 250 leaves a 50 residue
    log0.delete();
    send(0, 250);
    wait_done(0, s, r, rc);
    check("t4_short", 64'(s), 64'd1);
    check("t4_remaining", 64'(r), 64'd50);
    check("t4_coin_count", 64'(log0.size()), 64'd2);
    check("t4_inv_100", 64'(inv100[0]), 64'd15);

    // Hopper never acks: 16-cycle request then abort
    hop_en[0] = 1'b0;
    send(0, 500);
    wait_done(0, s, r, rc);
    check("t5_req_cycles", 64'(rc), 64'd16);
    check("t5_short", 64'(s), 64'd1);
    check("t5_remaining", 64'(r), 64'd500);
    check("t5_inv_500", 64'(inv500[0]), 64'd19);
    hop_en[0] = 1'b1;

    // Refill lands on the same edge as a 100-coin ack: 15 + 10 - 1
    send(0, 100);
    wait_req(0);
    refill[0] = 3'b001;
    @(posedge clk); #2;
    refill[0] = 3'b000;
    wait_done(0, s, r, rc);
    check("t6_short", 64'(s), 64'd0);
    check("t6_inv_100", 64'(inv100[0]), 64'd24);

    // Asynchronous reset in the middle of a dispense
    hop_en[0] = 1'b0;
    send(0, 500);
    wait_req(0);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_req", 64'(hreq[0]), 64'd0);
    check("t6_rst_inv_500", 64'(inv500[0]), 64'd20);
    check("t6_rst_inv_100", 64'(inv100[0]), 64'd20);
    check("t6_rst_inv1_1000", 64'(inv1000[1]), 64'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    hop_en[0] = 1'b1;

    // Recovery after reset
    log0.delete();
    send(0, 600);
    wait_done(0, s, r, rc);
    check("t7_short", 64'(s), 64'd0);
    check("t7_coin_count", 64'(log0.size()), 64'd2);
    check("t7_inv_500", 64'(inv500[0]), 64'd19);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
